mfcc_frame_packer: RTL and testbench

MFCC_FRAME_PACKER -- requirements
Module: mfcc_frame_packer

---
 rtl/mfcc_pkg.sv | 31 +++
 rtl/mfcc_frame_packer.sv | 157 +++++++++++++++
 tb/tb_mfcc_frame_packer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// Shared MFCC types, the frame packer state encoding and the default frame sync bytes.
package mfcc_pkg;

    // One cepstral coefficient as produced by the MFCC engine.
    typedef struct packed {
        logic [15:0] mfcc_sample;
    } mfcc_data_t;

    // Frame packer sequencing: idle, two sync bytes, sequence byte, payload, checksum.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        SEQ  = 3'd3,
        DATA = 3'd4,
        CSUM = 3'd5
    } packer_state_t;

    // Default sync pattern that starts every frame on the byte stream.
    localparam logic [7:0] PACKER_SYNC0 = 8'hA5;
    localparam logic [7:0] PACKER_SYNC1 = 8'h5A;

    // Bytes of framing around the payload: SYNC0, SYNC1, SEQ and CSUM.
    localparam int unsigned PACKER_OVERHEAD_BYTES = 4;

    // Increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mfcc_frame_packer.sv
// Packs one MFCC coefficient vector into a byte frame for a downstream FIFO:
// SYNC0, SYNC1, SEQ, payload (coefficient 0 first, low byte first), CSUM.
// The vector is captured on acceptance, so the source may change it freely
// afterwards. Vectors arriving while a frame is in flight are counted and dropped.
module mfcc_frame_packer
    import mfcc_pkg::*;
#(
    parameter int unsigned NUM_COEFFICIENTS = 12,
    parameter logic [7:0]  SYNC0            = PACKER_SYNC0,
    parameter logic [7:0]  SYNC1            = PACKER_SYNC1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mfcc_done_i,
    input  mfcc_data_t mfcc_data_i [NUM_COEFFICIENTS],
    input  logic       fifo_full_i,
    output logic       fifo_wr_en_o,
    output logic [7:0] fifo_data_o,
    output logic       busy_o,
    output logic [7:0] drop_count_o,
    output logic [7:0] seq_o
);

    localparam int unsigned DATA_BYTES = 2 * NUM_COEFFICIENTS;
    localparam int unsigned IDX_W      = (DATA_BYTES > 2) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    packer_state_t    state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       csum_reg, csum_next;
    logic [7:0]       seq_reg, seq_next;
    logic [7:0]       drop_reg, drop_next;

    // Captured coefficient vector and its view as a flat payload byte stream.
    logic [15:0]      sample_reg [NUM_COEFFICIENTS];
    logic [7:0]       byte_lane  [DATA_BYTES];

    logic             accept;
    logic             wr_en;
    logic [7:0]       data_byte;

    // Payload byte 2k is the low half of coefficient k, byte 2k+1 its high half.
    generate
        for (genvar gi = 0; gi < NUM_COEFFICIENTS; gi++) begin : g_lane
            assign byte_lane[2*gi]     = sample_reg[gi][7:0];
            assign byte_lane[2*gi + 1] = sample_reg[gi][15:8];
        end
    endgenerate

    // Capture the whole coefficient vector on the accepting cycle only.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int k = 0; k < NUM_COEFFICIENTS; k++) begin
                sample_reg[k] <= mfcc_data_i[k].mfcc_sample;
            end
        end
    end

    // Frame state, payload index, running checksum and the two counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            csum_reg  <= '0;
            seq_reg   <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            csum_reg  <= csum_next;
            seq_reg   <= seq_next;
            drop_reg  <= drop_next;
        end
    end

    // Next-state logic: every advance is tied to a byte actually written.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        csum_next  = csum_reg;
        seq_next   = seq_reg;
        drop_next  = drop_reg;
        accept     = (state_reg == IDLE) && mfcc_done_i;
        wr_en      = (state_reg != IDLE) && !fifo_full_i;

        // Any vector offered mid-frame (checksum cycle included) is discarded.
        if (mfcc_done_i && (state_reg != IDLE)) begin
            drop_next = sat_inc8(drop_reg);
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HDR0;
                    idx_next   = '0;
                    csum_next  = '0;
                end
            end
            HDR0: begin
                if (wr_en) begin
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (wr_en) begin
                    state_next = SEQ;
                end
            end
            SEQ: begin
                if (wr_en) begin
                    state_next = DATA;
                    csum_next  = csum_reg + seq_reg;
                end
            end
            DATA: begin
                if (wr_en) begin
                    csum_next = csum_reg + byte_lane[idx_reg];
                    if (idx_reg == LAST_IDX) begin
                        state_next = CSUM;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (wr_en) begin
                    state_next = IDLE;
                    seq_next   = seq_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte on offer, derived from registers only so it holds steady through a stall.
    always_comb begin
        data_byte = 8'h00;
        case (state_reg)
            HDR0:    data_byte = SYNC0;
            HDR1:    data_byte = SYNC1;
            SEQ:     data_byte = seq_reg;
            DATA:    data_byte = byte_lane[idx_reg];
            CSUM:    data_byte = csum_reg;
            default: data_byte = 8'h00;
        endcase
    end

    assign fifo_wr_en_o = wr_en;
    assign fifo_data_o  = data_byte;
    assign busy_o       = (state_reg != IDLE);
    assign drop_count_o = drop_reg;
    assign seq_o        = seq_reg;

endmodule

// File: tb/tb_mfcc_frame_packer.sv
// Self-checking bench for mfcc_frame_packer: every emitted frame is compared
// against a frame built from the coefficient vector with plain arithmetic.
module tb_mfcc_frame_packer;
    import mfcc_pkg::*;

    localparam int NC        = 12;
    localparam int FRAME_LEN = 2 * NC + PACKER_OVERHEAD_BYTES;

    logic       clk = 1'b0;
    logic       rst;
    logic       mfcc_done_i;
    mfcc_data_t mfcc_data_i [NC];
    logic       fifo_full_i;
    logic       fifo_wr_en_o;
    logic [7:0] fifo_data_o;
    logic       busy_o;
    logic [7:0] drop_count_o;
    logic [7:0] seq_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    byte unsigned wr_q[$];
    int           wr_cyc_q[$];
    byte unsigned exp_q[$];
    logic [15:0]  vec [NC];
    logic [7:0]   seq_model;

    mfcc_frame_packer #(.NUM_COEFFICIENTS(NC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mfcc_done_i  (mfcc_done_i),
        .mfcc_data_i  (mfcc_data_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o),
        .busy_o       (busy_o),
        .drop_count_o (drop_count_o),
        .seq_o        (seq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte the FIFO would accept, with the cycle it was written in.
    always @(negedge clk) begin
        if (fifo_wr_en_o === 1'b1) begin
            wr_q.push_back(fifo_data_o);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: sync, seq, payload low-then-high, sum of seq and payload mod 256.
    task automatic build_expected(input logic [7:0] s);
        int sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(s);
        sum = s;
        for (int k = 0; k < NC; k++) begin
            exp_q.push_back(vec[k] % 256);
            exp_q.push_back(vec[k] / 256);
            sum = sum + (vec[k] % 256) + (vec[k] / 256);
        end
        exp_q.push_back(sum % 256);
    endtask

    task automatic load_vec(input bit random_vec);
        for (int k = 0; k < NC; k++) begin
            vec[k] = random_vec ? 16'($urandom) : 16'(257 * k);
            mfcc_data_i[k].mfcc_sample = vec[k];
        end
    endtask

    // Present one done pulse, then scribble over the input vector.
    task automatic pulse_done();
        mfcc_done_i = 1'b1;
        tick();
        mfcc_done_i = 1'b0;
        for (int k = 0; k < NC; k++) mfcc_data_i[k].mfcc_sample = 16'($urandom);
    endtask

    task automatic clear_capture();
        wr_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int first_diff();
        if (wr_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        mfcc_done_i = 1'b0;
        fifo_full_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        seq_model = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mfcc_done_i = 1'b1;
        fifo_full_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy %b wr_en %b, need 0 0", busy_o, fifo_wr_en_o);
        end
        checks++;
        if (drop_count_o !== 8'h00 || seq_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_counts: drop %02h seq %02h, need 00 00", drop_count_o, seq_o);
        end
        rst = 1'b0;
        mfcc_done_i = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates_done: busy %b, need 0", busy_o);
        end
        seq_model = 8'h00;
        $display("reset: busy %b drop %02h seq %02h", busy_o, drop_count_o, seq_o);
    endtask

    task automatic test_nominal();
        int  d;
        int  done_cyc;
        bit  ok;
        load_vec(1'b0);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        done_cyc = cyc;
        wait_idle(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nominal_timeout: busy %b, need 0 within 60 cycles", busy_o);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL nominal_stream: got %0d bytes need %0d, first bad index %0d", wr_q.size(), exp_q.size(), d);
        end
        checks++;
        if (wr_q.size() != FRAME_LEN || wr_q[FRAME_LEN-1] !== 8'h84) begin
            errors++;
            $display("FAIL nominal_csum: got %0d bytes, last %02h, need 28 bytes ending 84", wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 8'h00);
        end
        checks++;
        if (wr_cyc_q.size() != FRAME_LEN || wr_cyc_q[0] != done_cyc || wr_cyc_q[FRAME_LEN-1] != done_cyc + FRAME_LEN - 1) begin
            errors++;
            $display("FAIL nominal_timing: %0d writes from cycle %0d, need 28 consecutive from %0d", wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, done_cyc);
        end
        seq_model = seq_model + 8'd1;
        checks++;
        if (seq_o !== seq_model) begin
            errors++;
            $display("FAIL nominal_seq: seq_o %02h, need %02h", seq_o, seq_model);
        end
        $display("nominal: frame %0d bytes csum %02h seq_o %02h", wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 8'h00, seq_o);
    endtask

    task automatic test_backpressure();
        int d;
        int done_cyc;
        apply_reset();
        load_vec(1'b0);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        done_cyc = cyc;
        // Cycles 9..13 after acceptance would present payload byte 6 (frame byte 9).
        for (int c = 0; c < 40; c++) begin
            fifo_full_i = (c >= 9 && c < 14);
            @(negedge clk);
            if (c >= 9 && c < 14) begin
                checks++;
                if (fifo_wr_en_o !== 1'b0 || fifo_data_o !== exp_q[9]) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d wr_en %b data %02h, need 0 %02h", c, fifo_wr_en_o, fifo_data_o, exp_q[9]);
                end
            end
            tick();
        end
        fifo_full_i = 1'b0;
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stall_stream: got %0d bytes need %0d, first bad index %0d", wr_q.size(), exp_q.size(), d);
        end
        checks++;
        if (wr_cyc_q.size() != FRAME_LEN || wr_cyc_q[0] != done_cyc || wr_cyc_q[FRAME_LEN-1] - wr_cyc_q[0] + 1 != 33) begin
            errors++;
            $display("FAIL stall_duration: %0d writes spanning %0d cycles, need 28 over 33", wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] + 1 : 0);
        end
        seq_model = seq_model + 8'd1;
        $display("backpressure: frame %0d bytes seq_o %02h", wr_q.size(), seq_o);
    endtask

    task automatic test_overlap();
        int d;
        bit ok;
        apply_reset();
        load_vec(1'b1);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        for (int i = 0; i < 9; i++) tick();
        for (int k = 0; k < NC; k++) mfcc_data_i[k].mfcc_sample = 16'($urandom);
        mfcc_done_i = 1'b1;
        tick();
        mfcc_done_i = 1'b0;
        wait_idle(60, ok);
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL overlap_stream: idle %b, got %0d bytes need %0d, first bad index %0d", ok, wr_q.size(), exp_q.size(), d);
        end
        checks++;
        if (drop_count_o !== 8'd1) begin
            errors++;
            $display("FAIL overlap_drop: drop %0d, need 1", drop_count_o);
        end
        seq_model = seq_model + 8'd1;
        load_vec(1'b1);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        wait_idle(60, ok);
        d = first_diff();
        checks++;
        if (!ok || d != -1 || wr_q[2] !== 8'h01) begin
            errors++;
            $display("FAIL overlap_next: idle %b, bad index %0d, seq byte %02h need 01", ok, d, (wr_q.size() > 2) ? wr_q[2] : 8'h00);
        end
        seq_model = seq_model + 8'd1;
        $display("overlap: drop %0d seq_o %02h", drop_count_o, seq_o);
    endtask

    task automatic test_random();
        int d;
        bit ok;
        for (int f = 0; f < 20; f++) begin
            load_vec(1'b1);
            build_expected(seq_model);
            clear_capture();
            pulse_done();
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                fifo_full_i = ($urandom_range(3) == 0);
                @(negedge clk);
                if (busy_o === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            fifo_full_i = 1'b0;
            d = first_diff();
            checks++;
            if (!ok || d != -1) begin
                errors++;
                $display("FAIL random_frame: frame %0d idle %b, got %0d bytes need %0d, first bad index %0d", f, ok, wr_q.size(), exp_q.size(), d);
            end
            seq_model = seq_model + 8'd1;
            checks++;
            if (seq_o !== seq_model || drop_count_o !== 8'd1) begin
                errors++;
                $display("FAIL random_counters: seq %02h drop %0d, need %02h 1", seq_o, drop_count_o, seq_model);
            end
            $display("random: frame %0d seq %02h csum %02h", f, exp_q[2], exp_q[FRAME_LEN-1]);
        end
    endtask

    task automatic test_saturation();
        int d;
        bit ok;
        apply_reset();
        load_vec(1'b1);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        for (int i = 0; i < 11; i++) tick();
        fifo_full_i = 1'b1;
        for (int p = 0; p < 300; p++) begin
            mfcc_done_i = 1'b1;
            tick();
            mfcc_done_i = 1'b0;
            tick();
        end
        @(negedge clk);
        checks++;
        if (drop_count_o !== 8'd255 || busy_o !== 1'b1 || fifo_wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL saturation: drop %0d busy %b wr_en %b, need 255 1 0", drop_count_o, busy_o, fifo_wr_en_o);
        end
        fifo_full_i = 1'b0;
        wait_idle(60, ok);
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL saturation_frame: idle %b, got %0d bytes need %0d, first bad index %0d", ok, wr_q.size(), exp_q.size(), d);
        end
        seq_model = seq_model + 8'd1;
        $display("saturation: drop %0d seq_o %02h", drop_count_o, seq_o);
    endtask

    task automatic test_wrap();
        int d;
        bit ok;
        apply_reset();
        for (int f = 0; f < 256; f++) begin
            load_vec(1'b1);
            build_expected(seq_model);
            clear_capture();
            pulse_done();
            wait_idle(60, ok);
            d = first_diff();
            checks++;
            if (!ok || d != -1) begin
                errors++;
                $display("FAIL wrap_frame: frame %0d idle %b, got %0d bytes need %0d, first bad index %0d", f, ok, wr_q.size(), exp_q.size(), d);
            end
            $display("wrap: frame %0d seq %02h", f + 1, (wr_q.size() > 2) ? wr_q[2] : 8'h00);
            seq_model = seq_model + 8'd1;
        end
        checks++;
        if (wr_q.size() < 3 || wr_q[2] !== 8'hFF || seq_o !== 8'h00) begin
            errors++;
            $display("FAIL wrap_seq: last seq byte %02h seq_o %02h, need FF 00", (wr_q.size() > 2) ? wr_q[2] : 8'h00, seq_o);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        bit ok;
        apply_reset();
        load_vec(1'b1);
        pulse_done();
        wait_idle(60, ok);
        load_vec(1'b1);
        pulse_done();
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        mfcc_done_i = 1'b1;
        tick();
        clear_capture();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_wr_en_o !== 1'b0 || busy_o !== 1'b0 || drop_count_o !== 8'h00 || seq_o !== 8'h00) begin
                errors++;
                $display("FAIL midreset_outputs: wr_en %b busy %b drop %02h seq %02h, need 0 0 00 00", fifo_wr_en_o, busy_o, drop_count_o, seq_o);
            end
            tick();
        end
        rst = 1'b0;
        mfcc_done_i = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_writes: %0d bytes written after reset, need 0", wr_q.size());
        end
        seq_model = 8'h00;
        load_vec(1'b1);
        build_expected(seq_model);
        clear_capture();
        pulse_done();
        wait_idle(60, ok);
        d = first_diff();
        checks++;
        if (!ok || d != -1 || wr_q[0] !== 8'hA5 || wr_q[1] !== 8'h5A || wr_q[2] !== 8'h00) begin
            errors++;
            $display("FAIL midreset_next: idle %b bad index %0d, got %0d bytes, need A5 5A 00 frame", ok, d, wr_q.size());
        end
        $display("reset_mid: next frame %0d bytes seq %02h", wr_q.size(), (wr_q.size() > 2) ? wr_q[2] : 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        mfcc_done_i = 1'b0;
        fifo_full_i = 1'b0;
        seq_model = 8'h00;
        for (int k = 0; k < NC; k++) mfcc_data_i[k].mfcc_sample = 16'h0000;
        test_reset();
        test_nominal();
        test_backpressure();
        test_overlap();
        test_random();
        test_saturation();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
